// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: walks soak/wash/rinse/spin steps, drives the step timer and actuators.
// Optional DOOR_LOCK_EN adds i_door_closed / o_lock interlocking.
module wash_sequencer #(
    parameter logic [15:0] SOAK_T     = 16'd300,
    parameter logic [15:0] WASH_T     = 16'd600,
    parameter logic [15:0] RINSE_T    = 16'd300,
    parameter logic [15:0] SPIN_T     = 16'd200,
    parameter logic [31:0] GAP_CYCLES = 32'd2400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_go,
    input  logic        i_abort,
    input  logic [1:0]  i_mode,
    input  logic [3:0]  i_response,
`ifdef DOOR_LOCK_EN
    input  logic        i_door_closed,
    output logic        o_lock,
`endif
    output logic        o_start,
    output logic [15:0] o_state,
    output logic [1:0]  o_step,
    output logic        o_timer_clr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_water_in,
    output logic        o_drain,
    output logic        o_motor,
    output logic        o_motor_fast
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RUN, S_NEXT, S_CLEAR, S_DONE
    } fsm_t;

    // GAP_CYCLES of 0 or 1 both collapse to a single ARM cycle
    localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 32'd1) ? GAP_CYCLES - 32'd1 : 32'd0;

    fsm_t        fsm_reg, fsm_next;
    logic [1:0]  step_reg, step_next;
    logic [15:0] dur_reg;
    logic [31:0] gap_cnt_reg, gap_cnt_next;
    logic [1:0]  mode_reg, mode_next;
    logic        abort_reg, abort_next;
    logic        go_prev_reg;
    logic [3:0]  resp_prev_reg;
    logic        step_load;

    logic go_ok, abort_req, resp_rise;

    function automatic logic [15:0] dur_of(input logic [1:0] s);
        case (s)
            2'd0:    dur_of = SOAK_T;
            2'd1:    dur_of = WASH_T;
            2'd2:    dur_of = RINSE_T;
            default: dur_of = SPIN_T;
        endcase
    endfunction

    assign resp_rise = i_response[step_reg] & ~resp_prev_reg[step_reg];

`ifdef DOOR_LOCK_EN
    assign go_ok     = i_go & ~go_prev_reg & i_door_closed;
    assign abort_req = i_abort | (~i_door_closed & ((fsm_reg == S_ARM) | (fsm_reg == S_RUN)));
`else
    assign go_ok     = i_go & ~go_prev_reg;
    assign abort_req = i_abort;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= S_IDLE;
            step_reg      <= 2'd0;
            dur_reg       <= 16'd0;
            gap_cnt_reg   <= 32'd0;
            mode_reg      <= 2'b00;
            abort_reg     <= 1'b0;
            go_prev_reg   <= 1'b0;
            resp_prev_reg <= 4'd0;
        end else begin
            fsm_reg       <= fsm_next;
            step_reg      <= step_next;
            gap_cnt_reg   <= gap_cnt_next;
            mode_reg      <= mode_next;
            abort_reg     <= abort_next;
            go_prev_reg   <= i_go;
            resp_prev_reg <= i_response;
            if (step_load)
                dur_reg <= dur_of(step_next);
        end
    end

    always_comb begin
        fsm_next     = fsm_reg;
        step_next    = step_reg;
        gap_cnt_next = gap_cnt_reg;
        mode_next    = mode_reg;
        abort_next   = abort_reg;
        step_load    = 1'b0;
        case (fsm_reg)
            S_IDLE, S_DONE: begin
                if (go_ok) begin
                    // first step of each program equals its mode code
                    mode_next    = i_mode;
                    step_next    = i_mode;
                    step_load    = 1'b1;
                    gap_cnt_next = 32'd0;
                    abort_next   = 1'b0;
                    fsm_next     = S_ARM;
                end
            end
            S_ARM: begin
                gap_cnt_next = gap_cnt_reg + 32'd1;
                if (abort_req) begin
                    abort_next = 1'b1;
                    fsm_next   = S_CLEAR;
                end else if (gap_cnt_reg >= GAP_LAST) begin
                    fsm_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_req) begin
                    abort_next = 1'b1;
                    fsm_next   = S_CLEAR;
                end else if (resp_rise) begin
                    fsm_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort_req) begin
                    abort_next = 1'b1;
                    fsm_next   = S_CLEAR;
                end else if (step_reg == 2'd3) begin
                    fsm_next = S_CLEAR;
                end else begin
                    step_next    = (step_reg == 2'd1 && mode_reg == 2'b01) ? 2'd3 : step_reg + 2'd1;
                    step_load    = 1'b1;
                    gap_cnt_next = 32'd0;
                    fsm_next     = S_ARM;
                end
            end
            S_CLEAR: fsm_next = abort_reg ? S_IDLE : S_DONE;
            default: fsm_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_start      = (fsm_reg == S_RUN);
        o_timer_clr  = (fsm_reg == S_CLEAR);
        o_busy       = (fsm_reg == S_ARM) || (fsm_reg == S_RUN) || (fsm_reg == S_NEXT);
        o_done       = (fsm_reg == S_DONE);
        o_water_in   = 1'b0;
        o_drain      = 1'b0;
        o_motor      = 1'b0;
        o_motor_fast = 1'b0;
        if (fsm_reg == S_RUN) begin
            case (step_reg)
                2'd0: o_water_in = 1'b1;
                2'd1: o_motor = 1'b1;
                2'd2: begin
                    o_water_in = 1'b1;
                    o_motor    = 1'b1;
                end
                default: begin
                    o_drain      = 1'b1;
                    o_motor      = 1'b1;
                    o_motor_fast = 1'b1;
                end
            endcase
        end
`ifdef DOOR_LOCK_EN
        o_lock = o_busy || (fsm_reg == S_CLEAR);
`endif
    end

    assign o_step  = step_reg;
    assign o_state = dur_reg;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: program table runs, corner-case sequences, randomized programs.
module tb_wash_sequencer;
    localparam logic [31:0] GAP = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_go = 1'b0;
    logic        i_abort = 1'b0;
    logic [1:0]  i_mode = 2'b00;
    logic [3:0]  i_response = 4'd0;
    logic        o_start, o_timer_clr, o_busy, o_done;
    logic [15:0] o_state;
    logic [1:0]  o_step;
    logic        o_water_in, o_drain, o_motor, o_motor_fast;
`ifdef DOOR_LOCK_EN
    logic        i_door_closed = 1'b1;
    logic        o_lock;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wash_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_abort(i_abort),
        .i_mode(i_mode), .i_response(i_response),
`ifdef DOOR_LOCK_EN
        .i_door_closed(i_door_closed), .o_lock(o_lock),
`endif
        .o_start(o_start), .o_state(o_state), .o_step(o_step),
        .o_timer_clr(o_timer_clr), .o_busy(o_busy), .o_done(o_done),
        .o_water_in(o_water_in), .o_drain(o_drain), .o_motor(o_motor),
        .o_motor_fast(o_motor_fast)
    );

    // Expected per-step outputs; act = {water_in, drain, motor, motor_fast}
    typedef struct { logic [15:0] dur; logic [3:0] act; } step_rec_t;
    // Program table: step list packed 2 bits per entry, entry 0 in the low bits
    typedef struct { logic [1:0] mode; int len; logic [7:0] seq; } prog_rec_t;

    step_rec_t step_tab [4];
    prog_rec_t prog_tab [4];

    function automatic logic [3:0] acts();
        return {o_water_in, o_drain, o_motor, o_motor_fast};
    endfunction

    function automatic logic [31:0] all_outs();
        return {6'd0, o_start, o_state, o_step, o_timer_clr, o_busy, o_done,
                o_water_in, o_drain, o_motor, o_motor_fast};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go_pulse(input logic [1:0] m);
        i_mode = m;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        i_mode = ~m;
    endtask

    task automatic await_fall();
        for (int g = 0; g < 20 && o_start; g++) tick();
        check("start_fall", o_start, 1'b0);
    endtask

    // Counts cycles spent busy with the timer stopped before RUN is reached
    task automatic await_run(output int low);
        low = 0;
        for (int g = 0; g < 100 && !o_start; g++) begin
            if (o_busy) low++;
            tick();
        end
        check("run_entry", o_start, 1'b1);
    endtask

    task automatic wait_clr();
        for (int g = 0; g < 20 && !o_timer_clr; g++) tick();
        check("clr_pulse", o_timer_clr, 1'b1);
        check("clr_acts", acts(), 4'd0);
        tick();
        check("clr_width", o_timer_clr, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
        check({tag, "_start"}, o_start, 1'b0);
        check({tag, "_acts"}, acts(), 4'd0);
    endtask

    task automatic run_prog(input logic [1:0] m, input int abort_idx, input bit abort_edge);
        prog_rec_t p;
        logic [1:0] s;
        int low;
        int stall;
        p = prog_tab[m];
        go_pulse(m);
        for (int i = 0; i < p.len; i++) begin
            s = p.seq[2*i +: 2];
            if (i > 0) await_fall();
            await_run(low);
            check("arm_len", low, (i == 0) ? GAP : GAP + 1);
            check("step", o_step, s);
            check("state", o_state, step_tab[s].dur);
            check("acts", acts(), step_tab[s].act);
            check("busy_run", {o_busy, o_done}, 2'b10);
            stall = $urandom_range(0, 4);
            repeat (stall) tick();
            check("hold_step", {o_start, o_step}, {1'b1, s});
            if (i == abort_idx) begin
                i_abort = 1'b1;
                if (abort_edge) i_response[s] = 1'b1;
                tick();
                i_abort = 1'b0;
                wait_clr();
                check_idle("abort");
                i_response = 4'd0;
                $display("[TB] mode=%0d aborted at step %0d (edge=%0d)", m, s, abort_edge);
                return;
            end
            i_response[s] = 1'b1;
            tick();
        end
        wait_clr();
        check("done", {o_done, o_busy, o_start}, 3'b100);
        i_response = 4'd0;
        $display("[TB] mode=%0d completed %0d steps", m, p.len);
    endtask

    initial begin
        int low;
        logic [1:0] m;
        int ai;

        step_tab[0] = '{16'd300, 4'b1000};
        step_tab[1] = '{16'd600, 4'b0010};
        step_tab[2] = '{16'd300, 4'b1010};
        step_tab[3] = '{16'd200, 4'b0111};
        prog_tab[0] = '{2'b00, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        prog_tab[1] = '{2'b01, 2, {4'd0, 2'd3, 2'd1}};
        prog_tab[2] = '{2'b10, 2, {4'd0, 2'd3, 2'd2}};
        prog_tab[3] = '{2'b11, 1, {6'd0, 2'd3}};

        #2;
        check("reset_outs", all_outs(), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_outs", all_outs(), 32'd0);

        // Table-driven: every program runs to completion
        for (int k = 0; k < 4; k++)
            run_prog(prog_tab[k].mode, -1, 1'b0);

        // Stale sticky bit 0 from an earlier run must not move the quick program
        i_response = 4'b0001;
        run_prog(2'b01, -1, 1'b0);

        // All bits already set at RUN entry: no advance until a fresh edge
        i_response = 4'b1111;
        go_pulse(2'b00);
        await_run(low);
        check("stuck_step0", o_step, 2'd0);
        repeat (6) tick();
        check("stuck_hold", {o_start, o_step}, {1'b1, 2'd0});
        i_response = 4'd0;
        tick();
        i_response[0] = 1'b1;
        tick();
        await_fall();
        await_run(low);
        check("fresh_edge_step", o_step, 2'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        wait_clr();
        check_idle("stuck_abort");
        i_response = 4'd0;
        $display("[TB] held-response sequence finished");

        // Abort on the same cycle as a step-1 edge
        run_prog(2'b00, 1, 1'b1);

        // Reset mid-RUN at step 2
        go_pulse(2'b00);
        for (int i = 0; i < 2; i++) begin
            await_run(low);
            i_response[i] = 1'b1;
            tick();
            await_fall();
        end
        await_run(low);
        check("pre_reset_step", o_step, 2'd2);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", all_outs(), 32'd0);
        tick();
        i_response = 4'd0;
        rst_n = 1'b1;
        tick();
        check("after_reset_outs", all_outs(), 32'd0);
        $display("[TB] mid-run reset sequence finished");
        run_prog(2'b00, -1, 1'b0);

`ifdef DOOR_LOCK_EN
        i_door_closed = 1'b0;
        go_pulse(2'b00);
        repeat (3) tick();
        check("door_open_go", {o_busy, o_lock}, 2'b00);
        i_door_closed = 1'b1;
        go_pulse(2'b00);
        await_run(low);
        check("lock_run", o_lock, 1'b1);
        i_door_closed = 1'b0;
        tick();
        wait_clr();
        check("door_abort", {o_busy, o_done, o_lock}, 3'b000);
        i_door_closed = 1'b1;
        $display("[TB] door interlock sequence finished");
`endif

        // Randomized programs against the program/step model
        for (int r = 0; r < 16; r++) begin
            m = 2'($urandom_range(0, 3));
            ai = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, prog_tab[m].len - 1)) : -1;
            run_prog(m, ai, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
